// File: rtl/gate_model_sequencer.sv
// rtl/gate_model_sequencer.sv - LFSR vector sequencer with MISR signature for gate-model self-test (optional comparator: GATE_SEQ_CHECK_EN)
module gate_model_sequencer #(
    parameter int NUM_IN        = 24,
    parameter int NUM_OUT       = 10,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        vec_count,
    input  logic [23:0]        seed,
    input  logic [15:0]        exp_sig,
    output logic [NUM_IN-1:0]  dut_in,
    input  logic [NUM_OUT-1:0] dut_out,
    output logic               busy,
    output logic               done,
    output logic [15:0]        signature,
    output logic [15:0]        vec_idx,
    output logic               pass
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] lfsr;
    logic [15:0] count;
    logic [15:0] settle_cnt;
    logic [23:0] seed_fix;
    logic [23:0] lfsr_step;
    logic [15:0] misr_next;
    logic        last_vec;
    logic        settle_end;

    // Derived values: zero-seed substitution, LFSR/MISR next values, loop exit tests
    always_comb begin
        seed_fix   = (seed == 24'h0) ? 24'h000001 : seed;
        lfsr_step  = {lfsr[22:0], lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16]};
        misr_next  = {signature[14:0], 1'b0}
                   ^ (signature[15] ? 16'h1021 : 16'h0000)
                   ^ 16'(dut_out);
        last_vec   = ({1'b0, vec_idx} + 17'd1) >= {1'b0, count};
        settle_end = settle_cnt == 16'(SETTLE_CYCLES - 1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; start is only looked at in IDLE so pulses while busy are dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = (vec_count == 16'h0) ? ST_DONE : ST_APPLY;
            ST_APPLY:   state_d = ST_SETTLE;
            ST_SETTLE:  if (settle_end) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = last_vec ? ST_DONE : ST_APPLY;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
    assign done = (state_q == ST_DONE);

    // Datapath: dut_in is loaded only on edges entering APPLY, MISR/LFSR/index step when leaving CAPTURE
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_in     <= '0;
            lfsr       <= 24'h000001;
            count      <= 16'h0;
            settle_cnt <= 16'h0;
            signature  <= 16'h0;
            vec_idx    <= 16'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        signature <= 16'h0;
                        vec_idx   <= 16'h0;
                        count     <= vec_count;
                        lfsr      <= seed_fix;
                        if (vec_count != 16'h0) dut_in <= NUM_IN'(seed_fix);
                    end
                end
                ST_APPLY: settle_cnt <= 16'h0;
                ST_SETTLE: settle_cnt <= settle_cnt + 16'h1;
                ST_CAPTURE: begin
                    signature <= misr_next;
                    lfsr      <= lfsr_step;
                    vec_idx   <= vec_idx + 16'h1;
                    if (!last_vec) dut_in <= NUM_IN'(lfsr_step);
                end
                default: ;
            endcase
        end
    end

`ifdef GATE_SEQ_CHECK_EN
    // Signature comparison registered on entry to DONE, cleared by an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            pass <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            pass <= (vec_count == 16'h0) ? (exp_sig == 16'h0) : 1'b0;
        end else if (state_q == ST_CAPTURE && last_vec) begin
            pass <= (misr_next == exp_sig);
        end
    end
`else
    logic unused_exp_sig;
    assign unused_exp_sig = ^exp_sig;
    assign pass = 1'b0;
`endif

endmodule
